// File: rtl/demux_pkg.sv
// Shared defaults and select decoding for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int N_DEFAULT     = 32;
  localparam int DEPTH_DEFAULT = 2;
  localparam int CW_DEFAULT    = 16;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_t;

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with occupancy count; head word is read combinationally
// from the storage array, so there is no path from DIN to DOUT.
module fifo_sync #(
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic         CLOCK,
  input  logic         nRESET,
  input  logic         CLEAR,
  input  logic         PUSH,
  input  logic [n-1:0] DIN,
  input  logic         POP,
  output logic [n-1:0] DOUT,
  output logic         FULL,
  output logic         EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  logic [n-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  // Push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = POP && !EMPTY && !CLEAR;
  assign do_push = PUSH && !CLEAR && (!FULL || do_pop);

  assign FULL  = (cnt_q == FULL_CNT);
  assign EMPTY = (cnt_q == '0);
  assign DOUT  = mem_q[rd_q];

  // Next pointers and occupancy; CLEAR flushes and overrides any handshake.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (CLEAR) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + PTR_ONE;
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
      else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; cleared on reset so an idle output reads zero.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q] <= DIN;
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: steers the input word to one of two
// independently buffered outputs and counts accepted words per output.
module demux2_stream
  import demux_pkg::*;
#(
  parameter int n     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = CW_DEFAULT
) (
  input  logic          CLOCK,
  input  logic          nRESET,
  input  logic          S,
  input  logic [n-1:0]  D,
  input  logic          IN_VALID,
  output logic          IN_READY,
  output logic [n-1:0]  Y0,
  output logic [n-1:0]  Y1,
  output logic          VALID0,
  output logic          VALID1,
  input  logic          READY0,
  input  logic          READY1,
  output logic [CW-1:0] COUNT0,
  output logic [CW-1:0] COUNT1,
  input  logic          CLEAR
);

  localparam logic [CW-1:0] CW_ONE = (CW)'(1);

  port_sel_t     sel;
  logic          full0, full1;
  logic          empty0, empty1;
  logic          pop0, pop1;
  logic          push0, push1;
  logic          accept;
  logic          sel_full;
  logic          sel_drain;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  assign sel    = port_sel_t'(S);
  assign VALID0 = !empty0;
  assign VALID1 = !empty1;
  assign pop0   = VALID0 && READY0;
  assign pop1   = VALID1 && READY1;

  // Status of the selected output; a full FIFO still takes a word if its head leaves now.
  always_comb begin
    sel_full  = full0;
    sel_drain = pop0;
    if (sel == PORT1) begin
      sel_full  = full1;
      sel_drain = pop1;
    end
  end

  assign IN_READY = !CLEAR && (!sel_full || sel_drain);
  assign accept   = IN_VALID && IN_READY;
  assign push0    = accept && (sel == PORT0);
  assign push1    = accept && (sel == PORT1);

  // Per-output accepted-word counters, wrapping naturally.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (CLEAR) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (push0) cnt0_d = cnt0_q + CW_ONE;
      if (push1) cnt1_d = cnt1_q + CW_ONE;
    end
  end

  // Counter registers.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign COUNT0 = cnt0_q;
  assign COUNT1 = cnt1_q;

  fifo_sync #(.n(n), .DEPTH(DEPTH)) u_fifo0 (
    .CLOCK (CLOCK),
    .nRESET(nRESET),
    .CLEAR (CLEAR),
    .PUSH  (push0),
    .DIN   (D),
    .POP   (pop0),
    .DOUT  (Y0),
    .FULL  (full0),
    .EMPTY (empty0)
  );

  fifo_sync #(.n(n), .DEPTH(DEPTH)) u_fifo1 (
    .CLOCK (CLOCK),
    .nRESET(nRESET),
    .CLEAR (CLEAR),
    .PUSH  (push1),
    .DIN   (D),
    .POP   (pop1),
    .DOUT  (Y1),
    .FULL  (full1),
    .EMPTY (empty1)
  );

endmodule

// File: tb/tb_demux2_stream.sv
// Bench for demux2_stream: scoreboard queues per output plus scenario tasks.
module tb_demux2_stream;

  localparam int W   = 32;
  localparam int DEP = 2;
  localparam int CWT = 4;

  logic           CLOCK = 1'b0;
  logic           nRESET;
  logic           S;
  logic [W-1:0]   D;
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   Y0, Y1;
  logic           VALID0, VALID1;
  logic           READY0, READY1;
  logic [CWT-1:0] COUNT0, COUNT1;
  logic           CLEAR;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   q0[$];
  logic [W-1:0]   q1[$];
  logic [CWT-1:0] m_cnt0 = '0;
  logic [CWT-1:0] m_cnt1 = '0;
  logic [W-1:0]   m_exp;
  logic           m_rdy;
  int             m_sz;

  demux2_stream #(.n(W), .DEPTH(DEP), .CW(CWT)) dut (
    .CLOCK   (CLOCK),
    .nRESET  (nRESET),
    .S       (S),
    .D       (D),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .Y0      (Y0),
    .Y1      (Y1),
    .VALID0  (VALID0),
    .VALID1  (VALID1),
    .READY0  (READY0),
    .READY1  (READY1),
    .COUNT0  (COUNT0),
    .COUNT1  (COUNT1),
    .CLEAR   (CLEAR)
  );

  always #5 CLOCK = ~CLOCK;

  // Scoreboard: sample late in the low phase, compare status, then apply handshakes.
  always begin
    @(negedge CLOCK);
    #3;
    if (!nRESET) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      checks++;
      if (VALID0 !== (q0.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid0 t=%0t got %b want %b", $time, VALID0, q0.size() != 0);
      end
      checks++;
      if (VALID1 !== (q1.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid1 t=%0t got %b want %b", $time, VALID1, q1.size() != 0);
      end
      checks++;
      if (COUNT0 !== m_cnt0 || COUNT1 !== m_cnt1) begin
        errors++;
        $display("FAIL sb_count t=%0t got %0d/%0d want %0d/%0d", $time, COUNT0, COUNT1, m_cnt0, m_cnt1);
      end
      m_sz  = (S == 1'b0) ? q0.size() : q1.size();
      m_rdy = !CLEAR && ((m_sz < DEP) || (m_sz != 0 && ((S == 1'b0) ? READY0 : READY1)));
      checks++;
      if (IN_READY !== m_rdy) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got %b want %b", $time, IN_READY, m_rdy);
      end
      if (CLEAR) begin
        q0.delete();
        q1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
      end else begin
        if (READY0 && q0.size() != 0) begin
          m_exp = q0.pop_front();
          checks++;
          if (Y0 !== m_exp) begin
            errors++;
            $display("FAIL sb_y0 t=%0t got %h want %h", $time, Y0, m_exp);
          end
        end
        if (READY1 && q1.size() != 0) begin
          m_exp = q1.pop_front();
          checks++;
          if (Y1 !== m_exp) begin
            errors++;
            $display("FAIL sb_y1 t=%0t got %h want %h", $time, Y1, m_exp);
          end
        end
        if (IN_VALID && m_rdy) begin
          if (S == 1'b0) begin
            q0.push_back(D);
            m_cnt0 = m_cnt0 + 4'd1;
          end else begin
            q1.push_back(D);
            m_cnt1 = m_cnt1 + 4'd1;
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge CLOCK);
    nRESET   = 1'b1;
    S        = 1'b0;
    D        = 32'h1234_5678;
    IN_VALID = 1'b1;
    READY0   = 1'b0;
    READY1   = 1'b0;
    @(negedge CLOCK);
    IN_VALID = 1'b0;
    @(negedge CLOCK);
    @(posedge CLOCK);
    #2 nRESET = 1'b0;
    #1;
    checks++;
    if (VALID0 !== 1'b0 || VALID1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b%b want 00", VALID0, VALID1);
    end
    checks++;
    if (COUNT0 !== '0 || COUNT1 !== '0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d want 0/0", COUNT0, COUNT1);
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", IN_READY);
    end
    checks++;
    if (Y0 !== '0 || Y1 !== '0) begin
      errors++;
      $display("FAIL reset_y got %h/%h want 0/0", Y0, Y1);
    end
    @(negedge CLOCK);
    @(negedge CLOCK);
    nRESET = 1'b1;
  endtask

  task automatic test_basic_steer();
    @(negedge CLOCK);
    READY0 = 1'b1; READY1 = 1'b1;
    S = 1'b0; D = 32'hAAAA_AAAA; IN_VALID = 1'b1;
    @(negedge CLOCK);
    checks++;
    if (VALID0 !== 1'b1 || Y0 !== 32'hAAAA_AAAA) begin
      errors++;
      $display("FAIL steer_y0 got %b/%h want 1/aaaaaaaa", VALID0, Y0);
    end
    S = 1'b1; D = 32'h5555_5555;
    @(negedge CLOCK);
    IN_VALID = 1'b0;
    checks++;
    if (VALID1 !== 1'b1 || Y1 !== 32'h5555_5555) begin
      errors++;
      $display("FAIL steer_y1 got %b/%h want 1/55555555", VALID1, Y1);
    end
    checks++;
    if (COUNT0 !== 4'd1 || COUNT1 !== 4'd1) begin
      errors++;
      $display("FAIL steer_count got %0d/%0d want 1/1", COUNT0, COUNT1);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_backpressure();
    @(negedge CLOCK);
    READY0 = 1'b1; READY1 = 1'b0;
    S = 1'b1; D = 32'h0000_0001; IN_VALID = 1'b1;
    @(negedge CLOCK);
    D = 32'h0000_0002;
    @(negedge CLOCK);
    D = 32'h0000_0003;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL bp_sel1_full got %b want 0", IN_READY);
    end
    S = 1'b0;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL bp_sel0_free got %b want 1", IN_READY);
    end
    @(negedge CLOCK);
    IN_VALID = 1'b0;
    checks++;
    if (VALID0 !== 1'b1 || Y0 !== 32'h0000_0003) begin
      errors++;
      $display("FAIL bp_y0 got %b/%h want 1/00000003", VALID0, Y0);
    end
    checks++;
    if (VALID1 !== 1'b1 || Y1 !== 32'h0000_0001) begin
      errors++;
      $display("FAIL bp_y1_head got %b/%h want 1/00000001", VALID1, Y1);
    end
    READY1 = 1'b1;
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic test_full_passthrough();
    @(negedge CLOCK);
    READY0 = 1'b0; READY1 = 1'b0;
    S = 1'b0; D = 32'hA1A1_0001; IN_VALID = 1'b1;
    @(negedge CLOCK);
    D = 32'hA1A1_0002;
    @(negedge CLOCK);
    D = 32'hA1A1_0003;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL pt_full_blocked got %b want 0", IN_READY);
    end
    READY0 = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL pt_full_pass got %b want 1", IN_READY);
    end
    @(negedge CLOCK);
    IN_VALID = 1'b0;
    READY0 = 1'b0;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL pt_still_full got %b want 0", IN_READY);
    end
    checks++;
    if (Y0 !== 32'hA1A1_0002) begin
      errors++;
      $display("FAIL pt_head got %h want a1a10002", Y0);
    end
    @(negedge CLOCK);
    READY0 = 1'b1;
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic test_counter_wrap();
    @(negedge CLOCK);
    CLEAR = 1'b1;
    @(negedge CLOCK);
    CLEAR = 1'b0;
    S = 1'b0; READY0 = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 17; i++) begin
      D = 32'h0000_0100 + W'(i);
      @(negedge CLOCK);
    end
    IN_VALID = 1'b0;
    checks++;
    if (COUNT0 !== 4'd1) begin
      errors++;
      $display("FAIL wrap_count0 got %0d want 1", COUNT0);
    end
    repeat (2) @(negedge CLOCK);
  endtask

  task automatic test_clear();
    @(negedge CLOCK);
    READY0 = 1'b0; READY1 = 1'b0;
    S = 1'b0; D = 32'hC0C0_C0C0; IN_VALID = 1'b1;
    @(negedge CLOCK);
    S = 1'b1; D = 32'hC1C1_C1C1;
    @(negedge CLOCK);
    CLEAR = 1'b1; S = 1'b0; D = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_ready got %b want 0", IN_READY);
    end
    @(negedge CLOCK);
    CLEAR = 1'b0; IN_VALID = 1'b0;
    checks++;
    if (VALID0 !== 1'b0 || VALID1 !== 1'b0) begin
      errors++;
      $display("FAIL clr_valid got %b%b want 00", VALID0, VALID1);
    end
    checks++;
    if (COUNT0 !== '0 || COUNT1 !== '0) begin
      errors++;
      $display("FAIL clr_count got %0d/%0d want 0/0", COUNT0, COUNT1);
    end
    READY0 = 1'b1; READY1 = 1'b1;
    repeat (2) @(negedge CLOCK);
    checks++;
    if (VALID0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_word_dropped got %b want 0", VALID0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK);
      S        = 1'($urandom_range(0, 1));
      D        = $urandom;
      IN_VALID = ($urandom_range(0, 3) != 0);
      READY0   = ($urandom_range(0, 2) != 0);
      READY1   = ($urandom_range(0, 2) != 0);
    end
    @(negedge CLOCK);
    IN_VALID = 1'b0; READY0 = 1'b1; READY1 = 1'b1;
    repeat (4) @(negedge CLOCK);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d/%0d left want 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    nRESET   = 1'b0;
    S        = 1'b0;
    D        = '0;
    IN_VALID = 1'b0;
    READY0   = 1'b0;
    READY1   = 1'b0;
    CLEAR    = 1'b0;
    test_reset();
    test_basic_steer();
    test_backpressure();
    test_full_passthrough();
    test_counter_wrap();
    test_clear();
    test_back_to_back();
    @(negedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
